// File: rtl/slice_addsub_pkg.sv
// slice_addsub_pkg
// Shared definitions for the bit-serial-by-slice adder/subtractor:
//   state_t      - controller states (IDLE, RUN, DONE)
//   DEF_WIDTH    - default operand/result width
//   DEF_SLICE    - default bits processed per cycle
package slice_addsub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice
// SLICE-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  : SLICE-bit operands (b already conditioned for subtraction)
//   cin   : carry into bit 0
//   sum   : SLICE-bit sum
//   cout  : carry out of bit SLICE-1
//   cmsb  : carry into bit SLICE-1 (used for signed overflow detection)
module addsub_slice
  import slice_addsub_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/slice_addsub.sv
// slice_addsub
// Multi-cycle adder/subtractor processing SLICE bits per clock, LSB slice
// first, N = WIDTH/SLICE cycles per operation.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation (in_ready = 1)
// RUN   | one slice per cycle through addsub_slice, carry registered
// DONE  | result and flags held until out_valid && out_ready
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub)
//   sub                  : 0 = a+b, 1 = a-b (b inverted, carry-in = 1)
//   out_valid / out_ready: result handshake
//   d                    : result modulo 2^WIDTH
//   cout                 : carry out (add) / no-borrow (sub)
//   ovf                  : two's-complement overflow
//   zero                 : d == 0
module slice_addsub
  import slice_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("slice_addsub: WIDTH must be a positive multiple of SLICE");
  end

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [SLICE-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;
  logic [WIDTH-1:0]   d_next;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[idx*SLICE +: SLICE]),
    .b    (b_q[idx*SLICE +: SLICE]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // Result with the current slice merged in; the final slice's view of this
  // is the complete result, so zero can be captured alongside d.
  always_comb begin
    d_next = d;
    d_next[idx*SLICE +: SLICE] = slice_sum;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      d     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d     <= d_next;
          carry <= slice_cout;
          if (idx == LAST) begin
            cout  <= slice_cout;
            ovf   <= slice_cmsb ^ slice_cout;
            zero  <= (d_next == '0);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_addsub.sv
// tb_slice_addsub
// Directed-vector bench for slice_addsub at WIDTH=16, SLICE=4.
module tb_slice_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int errors = 0;

  slice_addsub #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation at a negedge, have it accepted on the next posedge,
  // then count posedges until out_valid is seen (sampled at negedges).
  task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_sub);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_start", {31'd0, in_ready}, 32'd1);
    a        = op_a;
    b        = op_b;
    sub      = op_sub;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    sub      = ~op_sub;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_sub, input logic [15:0] exp_d, input logic exp_c,
                        input logic exp_v, input logic exp_z);
    int lat;
    start_op(op_a, op_b, op_sub);
    check({tag, "_run_in_ready"}, {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_d"}, {16'd0, d}, {16'd0, exp_d});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_v});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
    finish_op(tag);
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] held_d;
    logic [2:0]  held_f;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", {16'd0, d}, 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_3",       16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op("sub_3_5",       16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_1",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_abcd_abcd", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_op("add_0f0f_f0f0", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Back-pressure: hold DONE for 10 cycles with a stray in_valid pulse.
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, 32'd4);
    held_d = 16'h3333;
    held_f = 3'b000;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 16'h0000; b = 16'h0000; sub = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (d !== held_d || {cout, ovf, zero} !== held_f || !out_valid || in_ready) begin
        check("bp_hold_cycle", {i[7:0], 7'd0, in_ready, out_valid, cout, ovf, zero, d},
              {i[7:0], 7'd0, 1'b0, 1'b1, held_f, held_d});
      end
    end
    in_valid = 1'b0;
    check("bp_d_held", {16'd0, d}, 32'h3333);
    check("bp_flags_held", {29'd0, cout, ovf, zero}, 32'd0);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid_high", {31'd0, out_valid}, 32'd1);
    finish_op("bp");

    // Reset asserted during the second RUN cycle.
    start_op(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_d", {16'd0, d}, 32'd0);
    check("mid_rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_rst_no_out_valid", seen, 32'd0);
    run_op("post_rst_sub", 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
